// File: rtl/mux_6.sv
// rtl/mux_6.sv - 2:1 datapath selector with combinational and registered outputs
//
// Purpose : x = s ? b : a, combinationally. A registered copy x_q is also kept.
//           It is loaded on enabled edges and has a sticky valid flag and the
//           captured select value.
// Ports   : clk      - single clock, rising edge
//           rst      - synchronous, active-high reset (has priority over en)
//           en       - capture enable for the output register
//           a, b     - WIDTH-bit data inputs (a when s=0, b when s=1)
//           s        - select
//           x        - combinational result
//           x_q      - registered result, RST_VAL after reset
//           x_valid  - set by the first capture, cleared only by reset
//           sel_q    - s at the last capture
//           x_par    - even parity of x_q (only when MUX6_PARITY_EN is defined)
// Config  : MUX6_PARITY_EN adds the registered parity output x_par.
module mux_6 #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             s,
    output logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] x_q,
    output logic             x_valid,
    output logic             sel_q
`ifdef MUX6_PARITY_EN
    ,
    output logic             x_par
`endif
);

    logic [WIDTH-1:0] x_d;
    logic             sel_d;
    logic             valid_d;
    logic             valid_q;

    // A plain ?: is used so that an unknown select propagates X in simulation
    // rather than silently picking one input.
    always_comb begin
        x = s ? b : a;
    end

    always_comb begin
        x_d     = x_q;
        sel_d   = sel_q;
        valid_d = valid_q;
        if (en) begin
            x_d     = x;
            sel_d   = s;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q     <= RST_VAL;
            sel_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            x_q     <= x_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
        end
    end

    assign x_valid = valid_q;

`ifdef MUX6_PARITY_EN
    logic par_d;
    logic par_q;

    // The parity is computed from the selected data, not from x_q. This keeps
    // it in step with the register on the same edge.
    always_comb begin
        par_d = par_q;
        if (en) begin
            par_d = ^x;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            par_q <= ^RST_VAL;
        end else begin
            par_q <= par_d;
        end
    end

    assign x_par = par_q;
`endif

endmodule

// File: tb/tb_mux_6.sv
// tb/tb_mux_6.sv - directed self-checking bench for mux_6
module tb_mux_6;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        s;
    logic        a1, b1;
    logic        x1, x1_q, x1_valid, sel1_q;
    logic [15:0] a16, b16;
    logic [15:0] x16, x16_q;
    logic        x16_valid, sel16_q;
`ifdef MUX6_PARITY_EN
    logic        x1_par, x16_par;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mux_6 #(.WIDTH(1), .RST_VAL(1'b1)) u_w1 (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .a       (a1),
        .b       (b1),
        .s       (s),
        .x       (x1),
        .x_q     (x1_q),
        .x_valid (x1_valid),
        .sel_q   (sel1_q)
`ifdef MUX6_PARITY_EN
        ,
        .x_par   (x1_par)
`endif
    );

    mux_6 #(.WIDTH(16), .RST_VAL(16'hA5A5)) u_w16 (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .a       (a16),
        .b       (b16),
        .s       (s),
        .x       (x16),
        .x_q     (x16_q),
        .x_valid (x16_valid),
        .sel_q   (sel16_q)
`ifdef MUX6_PARITY_EN
        ,
        .x_par   (x16_par)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // a, b, s rows and the expected x for the WIDTH=1 truth table
    logic [2:0] tt_in  [8];
    logic       tt_exp [8];

    initial begin
        tt_in[0] = 3'b000; tt_exp[0] = 1'b0;
        tt_in[1] = 3'b010; tt_exp[1] = 1'b0;
        tt_in[2] = 3'b100; tt_exp[2] = 1'b1;
        tt_in[3] = 3'b110; tt_exp[3] = 1'b1;
        tt_in[4] = 3'b001; tt_exp[4] = 1'b0;
        tt_in[5] = 3'b011; tt_exp[5] = 1'b1;
        tt_in[6] = 3'b101; tt_exp[6] = 1'b0;
        tt_in[7] = 3'b111; tt_exp[7] = 1'b1;

        rst = 1'b0; en = 1'b0; s = 1'b0;
        a1 = 1'b0; b1 = 1'b0; a16 = 16'h0000; b16 = 16'h0000;

        // Truth table, combinational only
        for (int i = 0; i < 8; i++) begin
            a1 = tt_in[i][2];
            b1 = tt_in[i][1];
            s  = tt_in[i][0];
            #1;
            check($sformatf("truth_table_%0d", i), {63'd0, x1}, {63'd0, tt_exp[i]});
        end

        // Reset with en=1, a=1, s=0: reset wins, x still follows a
        tick();
        rst = 1'b1; en = 1'b1; a1 = 1'b1; s = 1'b0;
        tick();
        check("rst_w1_x_q",     {63'd0, x1_q},      64'd1);
        check("rst_w1_valid",   {63'd0, x1_valid},  64'd0);
        check("rst_w1_sel_q",   {63'd0, sel1_q},    64'd0);
        check("rst_w1_x",       {63'd0, x1},        64'd1);
        check("rst_w16_x_q",    {48'd0, x16_q},     64'hA5A5);
        check("rst_w16_valid",  {63'd0, x16_valid}, 64'd0);
        check("rst_w16_sel_q",  {63'd0, sel16_q},   64'd0);
`ifdef MUX6_PARITY_EN
        check("rst_w16_par",    {63'd0, x16_par},   64'd0);
`endif
        rst = 1'b0;

        // Capture, WIDTH=16
        a16 = 16'h1234; b16 = 16'hABCD; en = 1'b1; s = 1'b1;
        tick();
        check("cap1_x_q",   {48'd0, x16_q},     64'hABCD);
        check("cap1_sel_q", {63'd0, sel16_q},   64'd1);
        check("cap1_valid", {63'd0, x16_valid}, 64'd1);
        s = 1'b0;
        tick();
        check("cap2_x_q",   {48'd0, x16_q},     64'h1234);
        check("cap2_sel_q", {63'd0, sel16_q},   64'd0);
        check("cap2_valid", {63'd0, x16_valid}, 64'd1);

        // Hold for three edges with changed inputs
        en = 1'b0; a16 = 16'hFFFF; s = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("hold%0d_x_q", i),   {48'd0, x16_q},     64'h1234);
            check($sformatf("hold%0d_sel_q", i), {63'd0, sel16_q},   64'd0);
            check($sformatf("hold%0d_valid", i), {63'd0, x16_valid}, 64'd1);
            check($sformatf("hold%0d_x", i),     {48'd0, x16},       64'hABCD);
        end

        // Reset and enable together: reset wins
        rst = 1'b1; en = 1'b1; a16 = 16'h5555; s = 1'b0;
        tick();
        check("prio_x_q",   {48'd0, x16_q},     64'hA5A5);
        check("prio_valid", {63'd0, x16_valid}, 64'd0);
        check("prio_sel_q", {63'd0, sel16_q},   64'd0);
        check("prio_x",     {48'd0, x16},       64'h5555);
        rst = 1'b0;

        // Parity captures (x_q checked in every build)
        en = 1'b1; b16 = 16'h0007; s = 1'b1;
        tick();
        check("par1_x_q", {48'd0, x16_q}, 64'h0007);
`ifdef MUX6_PARITY_EN
        check("par1_x_par", {63'd0, x16_par}, 64'd1);
`endif
        a16 = 16'h0003; s = 1'b0;
        tick();
        check("par2_x_q", {48'd0, x16_q}, 64'h0003);
`ifdef MUX6_PARITY_EN
        check("par2_x_par", {63'd0, x16_par}, 64'd0);
`endif
        // Parity holds when en drops
        en = 1'b0; b16 = 16'h0001; s = 1'b1;
        tick();
        check("par3_x_q", {48'd0, x16_q}, 64'h0003);
`ifdef MUX6_PARITY_EN
        check("par3_x_par", {63'd0, x16_par}, 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
